calc_gen: RTL and testbench

CALC_GEN -- requirements
Module: calc_gen

---
 rtl/calc_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 tb/tb_calc_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_gen.sv
// rtl/calc_gen.sv - decimal four-function calculator with serial BCD digit printout
module calc_gen #(
  parameter int NDIG = 8,
  parameter int W    = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic [1:0] status,
  output logic [3:0] data,
  output logic [3:0] pos,
  output logic       neg
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    COMPUTE = 3'd2,
    PRINT   = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [3:0] CMD_EQ  = 4'd14;
  localparam logic [3:0] CMD_BS  = 4'd15;

  // Wide enough to hold a full 2W-bit product or a W+1-bit sum for range checks.
  localparam int XW = 2 * W + 1;
  localparam int IW = $clog2(W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Largest value that fits in NDIG decimal digits.
  localparam logic [XW-1:0] MAXV = XW'(pow10(NDIG) - 64'd1);

  // Count of significant decimal digits in v; zero has no digits.
  function automatic logic [3:0] ndigits(input logic [W-1:0] v);
    logic [63:0] p;
    logic [3:0]  n;
    p = 64'd1;
    n = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (64'(v) >= p) n = n + 4'd1;
      p = p * 64'd10;
    end
    return n;
  endfunction

  // Architectural state
  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic [3:0]      r_cnt_a;
  logic [3:0]      r_cnt_b;
  logic            r_fresh;
  logic            r_neg;
  logic [W-1:0]    r_shadow;
  logic [2*W-1:0]  r_prod;
  logic [IW-1:0]   r_iter;
  logic [3:0]      r_pos;
  logic            r_ret_b;

  // Next-state values
  state_t          w_state_n;
  logic [W-1:0]    w_a_n;
  logic [W-1:0]    w_b_n;
  logic [1:0]      w_op_n;
  logic [3:0]      w_cnt_a_n;
  logic [3:0]      w_cnt_b_n;
  logic            w_fresh_n;
  logic            w_neg_n;
  logic [W-1:0]    w_shadow_n;
  logic [2*W-1:0]  w_prod_n;
  logic [IW-1:0]   w_iter_n;
  logic [3:0]      w_pos_n;
  logic            w_ret_b_n;

  // Completion handshake inside the next-state logic
  logic            w_done;
  logic            w_err;
  logic [W-1:0]    w_res;
  logic            w_res_neg;

  // Command decode
  logic            w_accept;
  logic            w_is_digit;
  logic [1:0]      w_op_code;

  // Entry helpers; a fresh result is discarded when a new number starts
  logic [W-1:0]    w_a_base;
  logic [3:0]      w_cnt_a_base;
  logic [W-1:0]    w_a_push;
  logic [W-1:0]    w_b_push;
  logic [W-1:0]    w_a_pop;
  logic [W-1:0]    w_b_pop;

  // Arithmetic datapath
  logic [W:0]      w_add;
  logic            w_add_ovf;
  logic            w_b_gt_a;
  logic [W-1:0]    w_sub;
  logic [W:0]      w_mul_sum;
  logic [2*W-1:0]  w_mul_step;
  logic            w_mul_ovf;
  logic [W:0]      w_div_rem;
  logic [W:0]      w_div_diff;
  logic [2*W-1:0]  w_div_step;
  logic            w_last;

  // Printout
  logic [3:0]      w_print_digit;
  logic [W-1:0]    w_shadow_div;

  assign w_accept     = cmd_valid && ((r_state == ENTER_A) || (r_state == ENTER_B));
  assign w_is_digit   = (cmd <= 4'd9);
  // Maps commands 10..13 onto 0..3 (add, sub, mul, div).
  assign w_op_code    = cmd[1:0] + 2'd2;

  assign w_a_base     = r_fresh ? '0 : r_a;
  assign w_cnt_a_base = r_fresh ? 4'd0 : r_cnt_a;
  assign w_a_push     = w_a_base * W'(10) + W'(cmd);
  assign w_b_push     = r_b * W'(10) + W'(cmd);
  assign w_a_pop      = r_a / W'(10);
  assign w_b_pop      = r_b / W'(10);

  assign w_add        = {1'b0, r_a} + {1'b0, r_b};
  assign w_add_ovf    = {{W{1'b0}}, w_add} > MAXV;
  assign w_b_gt_a     = r_b > r_a;
  assign w_sub        = w_b_gt_a ? (r_b - r_a) : (r_a - r_b);

  // Shift-add multiply: high half accumulates A, low half shifts out B's bits.
  assign w_mul_sum    = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_mul_step   = {w_mul_sum, r_prod[W-1:1]};
  assign w_mul_ovf    = {1'b0, w_mul_step} > MAXV;

  // Restoring divide: high half is the remainder, low half shifts A out and the quotient in.
  assign w_div_rem    = {r_prod[2*W-1:W], r_prod[W-1]};
  assign w_div_diff   = w_div_rem - {1'b0, r_b};
  assign w_div_step   = w_div_diff[W] ? {w_div_rem[W-1:0], r_prod[W-2:0], 1'b0}
                                      : {w_div_diff[W-1:0], r_prod[W-2:0], 1'b1};

  assign w_last        = (r_iter == IW'(W - 1));
  assign w_print_digit = 4'(r_shadow % W'(10));
  assign w_shadow_div  = r_shadow / W'(10);

  // Next-state and datapath update for every state of the calculator.
  always_comb begin
    w_state_n  = r_state;
    w_a_n      = r_a;
    w_b_n      = r_b;
    w_op_n     = r_op;
    w_cnt_a_n  = r_cnt_a;
    w_cnt_b_n  = r_cnt_b;
    w_fresh_n  = r_fresh;
    w_neg_n    = r_neg;
    w_shadow_n = r_shadow;
    w_prod_n   = r_prod;
    w_iter_n   = r_iter;
    w_pos_n    = r_pos;
    w_ret_b_n  = r_ret_b;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_res      = '0;
    w_res_neg  = 1'b0;

    case (r_state)
      ENTER_A: begin
        if (w_accept) begin
          w_fresh_n = 1'b0;
          if (w_is_digit) begin
            if (r_fresh) w_neg_n = 1'b0;
            if (w_cnt_a_base < 4'(NDIG)) begin
              w_a_n      = w_a_push;
              w_cnt_a_n  = w_cnt_a_base + 4'd1;
              w_shadow_n = w_a_push;
              w_pos_n    = 4'd0;
              w_ret_b_n  = 1'b0;
              w_state_n  = PRINT;
            end
          end else if (cmd == CMD_BS) begin
            if (r_cnt_a != 4'd0) begin
              w_a_n      = w_a_pop;
              w_cnt_a_n  = r_cnt_a - 4'd1;
              w_shadow_n = w_a_pop;
              w_pos_n    = 4'd0;
              w_ret_b_n  = 1'b0;
              w_state_n  = PRINT;
            end
          end else if (cmd != CMD_EQ) begin
            w_op_n    = w_op_code;
            w_b_n     = '0;
            w_cnt_b_n = 4'd0;
            w_state_n = ENTER_B;
          end
        end
      end

      ENTER_B: begin
        if (w_accept) begin
          if (w_is_digit) begin
            if (r_cnt_b < 4'(NDIG)) begin
              w_b_n      = w_b_push;
              w_cnt_b_n  = r_cnt_b + 4'd1;
              w_shadow_n = w_b_push;
              w_pos_n    = 4'd0;
              w_ret_b_n  = 1'b1;
              w_state_n  = PRINT;
            end
          end else if (cmd == CMD_BS) begin
            if (r_cnt_b != 4'd0) begin
              w_b_n      = w_b_pop;
              w_cnt_b_n  = r_cnt_b - 4'd1;
              w_shadow_n = w_b_pop;
              w_pos_n    = 4'd0;
              w_ret_b_n  = 1'b1;
              w_state_n  = PRINT;
            end
          end else if (cmd == CMD_EQ) begin
            w_iter_n  = '0;
            w_prod_n  = (r_op == OP_DIV) ? {{W{1'b0}}, r_a} : {{W{1'b0}}, r_b};
            w_state_n = COMPUTE;
          end else begin
            w_state_n = ERROR;
          end
        end
      end

      COMPUTE: begin
        case (r_op)
          OP_ADD: begin
            if (w_add_ovf) begin
              w_err = 1'b1;
            end else begin
              w_done = 1'b1;
              w_res  = w_add[W-1:0];
            end
          end
          OP_SUB: begin
            w_done    = 1'b1;
            w_res     = w_sub;
            w_res_neg = w_b_gt_a;
          end
          OP_MUL: begin
            w_prod_n = w_mul_step;
            w_iter_n = r_iter + IW'(1);
            if (w_last) begin
              if (w_mul_ovf) begin
                w_err = 1'b1;
              end else begin
                w_done = 1'b1;
                w_res  = w_mul_step[W-1:0];
              end
            end
          end
          OP_DIV: begin
            if ((r_iter == '0) && (r_b == '0)) begin
              w_err = 1'b1;
            end else begin
              w_prod_n = w_div_step;
              w_iter_n = r_iter + IW'(1);
              if (w_last) begin
                w_done = 1'b1;
                w_res  = w_div_step[W-1:0];
              end
            end
          end
        endcase
      end

      PRINT: begin
        w_shadow_n = w_shadow_div;
        w_pos_n    = r_pos + 4'd1;
        if (r_pos == 4'(NDIG - 1)) begin
          w_pos_n   = 4'd0;
          w_state_n = r_ret_b ? ENTER_B : ENTER_A;
        end
      end

      ERROR: begin
        if (cmd_valid && (cmd == CMD_BS)) begin
          w_a_n      = '0;
          w_b_n      = '0;
          w_op_n     = OP_ADD;
          w_cnt_a_n  = 4'd0;
          w_cnt_b_n  = 4'd0;
          w_fresh_n  = 1'b0;
          w_neg_n    = 1'b0;
          w_shadow_n = '0;
          w_prod_n   = '0;
          w_iter_n   = '0;
          w_pos_n    = 4'd0;
          w_ret_b_n  = 1'b0;
          w_state_n  = ENTER_A;
        end
      end

      default: begin
        w_state_n = ENTER_A;
      end
    endcase

    if (w_done) begin
      w_a_n      = w_res;
      w_cnt_a_n  = ndigits(w_res);
      w_fresh_n  = 1'b1;
      w_neg_n    = w_res_neg;
      w_shadow_n = w_res;
      w_pos_n    = 4'd0;
      w_ret_b_n  = 1'b0;
      w_state_n  = PRINT;
    end
    if (w_err) begin
      w_state_n = ERROR;
    end
  end

  // State register; reset aborts any compute or printout immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ENTER_A;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Operand, flag, shadow and iteration registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_cnt_a  <= 4'd0;
      r_cnt_b  <= 4'd0;
      r_fresh  <= 1'b0;
      r_neg    <= 1'b0;
      r_shadow <= '0;
      r_prod   <= '0;
      r_iter   <= '0;
      r_pos    <= 4'd0;
      r_ret_b  <= 1'b0;
    end else begin
      r_a      <= w_a_n;
      r_b      <= w_b_n;
      r_op     <= w_op_n;
      r_cnt_a  <= w_cnt_a_n;
      r_cnt_b  <= w_cnt_b_n;
      r_fresh  <= w_fresh_n;
      r_neg    <= w_neg_n;
      r_shadow <= w_shadow_n;
      r_prod   <= w_prod_n;
      r_iter   <= w_iter_n;
      r_pos    <= w_pos_n;
      r_ret_b  <= w_ret_b_n;
    end
  end

  // Status encoding and printout outputs; data and pos idle at zero outside PRINT.
  always_comb begin
    status = 2'b10;
    data   = 4'd0;
    pos    = 4'd0;
    neg    = r_neg;
    case (r_state)
      ENTER_A, ENTER_B: status = 2'b10;
      COMPUTE:          status = 2'b01;
      PRINT: begin
        status = 2'b11;
        data   = w_print_digit;
        pos    = r_pos;
      end
      ERROR:            status = 2'b00;
      default:          status = 2'b10;
    endcase
  end

endmodule

// File: tb/tb_calc_gen.sv
// tb/tb_calc_gen.sv - randomized self-checking bench for calc_gen against a decimal reference model
module tb_calc_gen;

  localparam int NDIG = 8;
  localparam int W    = 27;
  localparam longint MAXL = 64'd99999999;

  logic       clock;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic       neg;

  int n_checks;
  int n_fail;
  bit noise_en;

  // Reference model: calculator mode 0 = entering A, 1 = entering B, 2 = error
  int     m_mode;
  longint m_a;
  longint m_b;
  int     m_na;
  int     m_nb;
  int     m_op;
  bit     m_fresh;
  bit     m_neg;

  calc_gen #(.NDIG(NDIG), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .neg       (neg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ndig_of(input longint v);
    int n;
    n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_a     = 0;
    m_b     = 0;
    m_na    = 0;
    m_nb    = 0;
    m_op    = 10;
    m_fresh = 0;
    m_neg   = 0;
  endtask

  task automatic drive_noise();
    cmd_valid = noise_en && ($urandom_range(0, 1) == 1);
    cmd       = 4'($urandom_range(0, 15));
  endtask

  // Called at a falling edge; presents one command and checks everything it causes.
  task automatic do_cmd(input logic [3:0] c);
    int     busy;
    int     n;
    bit     pr;
    bit     bad;
    bit     ng;
    bit     was_fresh;
    longint pv;
    longint r;
    busy = 0;
    pr   = 0;
    pv   = 0;
    r    = 0;
    bad  = 0;
    ng   = 0;
    case (m_mode)
      0: begin
        was_fresh = m_fresh;
        m_fresh   = 0;
        if (c <= 9) begin
          if (was_fresh) begin
            m_a   = 0;
            m_na  = 0;
            m_neg = 0;
          end
          if (m_na < NDIG) begin
            m_a = m_a * 10 + longint'(c);
            m_na++;
            pr = 1;
            pv = m_a;
          end
        end else if (c == 15) begin
          if (m_na > 0) begin
            m_a = m_a / 10;
            m_na--;
            pr = 1;
            pv = m_a;
          end
        end else if (c != 14) begin
          m_op   = int'(c);
          m_b    = 0;
          m_nb   = 0;
          m_mode = 1;
        end
      end
      1: begin
        if (c <= 9) begin
          if (m_nb < NDIG) begin
            m_b = m_b * 10 + longint'(c);
            m_nb++;
            pr = 1;
            pv = m_b;
          end
        end else if (c == 15) begin
          if (m_nb > 0) begin
            m_b = m_b / 10;
            m_nb--;
            pr = 1;
            pv = m_b;
          end
        end else if (c == 14) begin
          case (m_op)
            10: begin r = m_a + m_b; busy = 1; end
            11: begin
              busy = 1;
              if (m_b > m_a) begin r = m_b - m_a; ng = 1; end
              else r = m_a - m_b;
            end
            12: begin r = m_a * m_b; busy = W; end
            default: begin
              if (m_b == 0) begin bad = 1; busy = 1; end
              else begin r = m_a / m_b; busy = W; end
            end
          endcase
          if (!bad && r > MAXL) bad = 1;
          if (bad) begin
            m_mode = 2;
          end else begin
            m_a     = r;
            m_na    = ndig_of(r);
            m_fresh = 1;
            m_neg   = ng;
            m_mode  = 0;
            pr      = 1;
            pv      = r;
          end
        end else begin
          m_mode = 2;
        end
      end
      default: begin
        if (c == 15) model_reset();
      end
    endcase

    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;

    if (busy > 0) begin
      n = 0;
      while (status == 2'b01 && n < 1000) begin
        n++;
        drive_noise();
        @(negedge clock);
        cmd_valid = 1'b0;
      end
      check("busy_cycles", 64'(n), 64'(busy));
    end

    if (pr) begin
      for (int k = 0; k < NDIG; k++) begin
        check("prt_status", 64'(status), 64'd3);
        check("prt_pos", 64'(pos), 64'(k));
        check("prt_data", 64'(data), 64'(pv % 10));
        check("prt_neg", 64'(neg), 64'(m_neg));
        pv = pv / 10;
        drive_noise();
        @(negedge clock);
        cmd_valid = 1'b0;
      end
    end

    check("end_status", 64'(status), (m_mode == 2) ? 64'd0 : 64'd2);
    check("idle_pos", 64'(pos), 64'd0);
    check("idle_data", 64'(data), 64'd0);
    check("idle_neg", 64'(neg), 64'(m_neg));
  endtask

  task automatic do_seq(input logic [3:0] s[]);
    foreach (s[i]) do_cmd(s[i]);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  initial begin
    int pc;
    int r;
    logic [3:0] c;
    n_checks  = 0;
    n_fail    = 0;
    noise_en  = 0;
    reset     = 1'b1;
    cmd       = 4'd0;
    cmd_valid = 1'b0;
    model_reset();
    apply_reset();

    // Power-up state
    check("rst_status", 64'(status), 64'd2);
    check("rst_pos", 64'(pos), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_neg", 64'(neg), 64'd0);

    // 12 + 34 = 46
    do_seq('{4'd1, 4'd2, 4'd10, 4'd3, 4'd4, 4'd14});
    // 5 - 9 = -4, then chain + 1 = 5
    do_seq('{4'd5, 4'd11, 4'd9, 4'd14});
    do_seq('{4'd10, 4'd1, 4'd14});
    // 12 * 3 = 36 over W busy cycles
    do_seq('{4'd1, 4'd2, 4'd12, 4'd3, 4'd14});
    // divide by zero, recover, then multiply overflow
    do_seq('{4'd7, 4'd13, 4'd0, 4'd14});
    do_seq('{4'd15});
    do_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd12, 4'd2, 4'd14});
    do_seq('{4'd15});
    // backspace, then nine 9s with the ninth dropped
    do_seq('{4'd1, 4'd2, 4'd3, 4'd15});
    apply_reset();
    do_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
    // 99999999 / 7 exercises the full divider
    do_seq('{4'd13, 4'd7, 4'd14});

    // Reset during multiply aborts with no printout
    apply_reset();
    do_seq('{4'd1, 4'd2, 4'd12, 4'd3});
    cmd       = 4'd14;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("mul_busy", 64'(status), 64'd1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_status", 64'(status), 64'd2);
    check("abort_pos", 64'(pos), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    pc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (status != 2'b10) pc++;
    end
    check("abort_quiet", 64'(pc), 64'd0);
    do_seq('{4'd2, 4'd10, 4'd3, 4'd14});

    // Randomized traffic with ignored commands injected during busy/print
    noise_en = 1;
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2) begin
        c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'd15;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 55)      c = 4'($urandom_range(0, 9));
        else if (r < 65) c = 4'd15;
        else if (r < 82) c = 4'($urandom_range(10, 13));
        else             c = 4'd14;
        if (m_mode == 1 && c >= 10 && c <= 13 && $urandom_range(0, 3) != 0) c = 4'd14;
      end
      do_cmd(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
